video_timing_gen: RTL

- Parametrised raster timing generator, successor to the fixed 640x480 sync block.
- Produces the pixel-rate enable, H/V sync with selectable polarity, data-enable, pixel coordinates and line/frame start strobes for any CEA/VESA-style mode.
- Sits between the system clock and the pixel/pattern pipeline feeding the HDMI/VGA encoder.
- Adds a run enable and a configurable clock divider.

---
 rtl/video_timing_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel-rate enable, syncs, data enable, coordinates, line/frame strobes.
// Optional macro VIDEO_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  // Illegal parameter sets are rejected while the design is elaborated.
  if (H_SYNC < 1 || V_SYNC < 1 || CLK_DIV < 1 ||
      H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_param_err
    $error("video_timing_gen: illegal parameter set (sync width, CLK_DIV or totals vs CNT_W)");
  end

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             in_de;
  logic             in_hs;
  logic             in_vs;

  assign p_tick = en && (div == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (p_tick) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    in_de = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    in_hs = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    in_vs = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  end

  // All outputs come from one register stage so they stay aligned and glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (p_tick) begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      de          <= in_de;
      hsync       <= in_hs ? HS_ON : ~HS_ON;
      vsync       <= in_vs ? VS_ON : ~VS_ON;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (p_tick && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
